uar_transmitter: RTL and testbench

Serial UART transmitter for the asynchronous serial link, the transmit-side counterpart of the sampled UART receive path. It accepts one byte per valid/ready handshake and serialises it as a standard asynchronous frame on a single line: start bit, data bits LSB-first, optional parity, then stop bit(s). Bit timing is derived from the system clock by an integer divider. At the default 100 MHz / 9600 baud the bit period is 10416 cycles.

---
 rtl/uar_transmitter.sv | 158 +++++++++++++++
 tb/tb_uar_transmitter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uar_transmitter.sv
// uar_transmitter: asynchronous serial transmitter.
// Sends start bit, DATA_BITS data bits LSB first, optional parity and stop bit(s).
// Bit timing comes from an integer divide of the system clock.
module uar_transmitter #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid_in,
    output logic                 data_ready_out,
    output logic                 busy_out,
    output logic                 tx_out
);

    localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT);
    localparam int unsigned IDX_W          = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;

    assign bit_end        = (cnt_q == CNT_LAST);
    assign tx_out         = tx_q;
    assign data_ready_out = ready_q;
    assign busy_out       = busy_q;

    // State and datapath registers; reset forces an idle line immediately.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead so they can be registered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;

        if (state_q == S_IDLE || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (data_valid_in && ready_q) begin
                    shreg_d = data_in;
                    par_d   = (PARITY == 1) ? ~^data_in : ^data_in;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    idx_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uar_transmitter.sv
// Bench for uar_transmitter: three configurations (8N1, 8E2, 8O1) at 8 clocks per bit.
// A line monitor per instance decodes frames and compares them to a queue of sent bytes.
module tb_uar_transmitter;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 115_200;   // 1e6/115200 truncates to 8
    localparam int          C      = 8;
    localparam int          NDUT   = 3;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] din  [NDUT];
    logic       vld  [NDUT];
    logic       rdy  [NDUT];
    logic       busy [NDUT];
    logic       tx   [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    logic [7:0] sb2[$];

    // Free-running clock.
    always #5 clk_in = ~clk_in;

    // Cycle counter for interval measurements.
    always @(posedge clk_in) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uar_transmitter #(
            .CLK_HZ   (CLK_HZ),
            .BAUD     (BAUD),
            .DATA_BITS(8),
            .PARITY   (g == 1 ? 2 : (g == 2 ? 1 : 0)),
            .STOP_BITS(g == 1 ? 2 : 1)
        ) u_dut (
            .clk_in        (clk_in),
            .rst_in        (rst_n),
            .data_in       (din[g]),
            .data_valid_in (vld[g]),
            .data_ready_out(rdy[g]),
            .busy_out      (busy[g]),
            .tx_out        (tx[g])
        );
    end

    function automatic int cfg_par(input int g);
        return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    endfunction

    function automatic int cfg_stop(input int g);
        return (g == 1) ? 2 : 1;
    endfunction

    function automatic int nbits(input int g);
        return 1 + 8 + ((cfg_par(g) != 0) ? 1 : 0) + cfg_stop(g);
    endfunction

    // Parity bit that makes the total count of ones odd (1) or even (2).
    function automatic logic par_model(input int g, input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (cfg_par(g) == 2) return logic'(ones % 2);
        return logic'(1 - (ones % 2));
    endfunction

    function automatic void sb_push(input int g, input logic [7:0] v);
        case (g)
            0: sb0.push_back(v);
            1: sb1.push_back(v);
            default: sb2.push_back(v);
        endcase
    endfunction

    function automatic int sb_size(input int g);
        case (g)
            0: return sb0.size();
            1: return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic logic [7:0] sb_pop(input int g);
        case (g)
            0: return sb0.pop_front();
            1: return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Decodes every frame on tx[g], checking bit timing, payload, parity, stop and ready timing.
    task automatic monitor(input int g);
        int         n;
        int         unstable;
        bit         aborted;
        logic [11:0] bits;
        logic       last_rdy;
        logic       last_busy;
        logic [7:0] exp;
        n = nbits(g);
        forever begin
            @(posedge clk_in);
            #1;
            if (rst_n && !tx[g]) begin
                aborted   = 1'b0;
                unstable  = 0;
                bits      = '0;
                last_rdy  = 1'b0;
                last_busy = 1'b0;
                for (int j = 0; j < n && !aborted; j++) begin
                    for (int c = 0; c < C && !aborted; c++) begin
                        if (j != 0 || c != 0) begin
                            @(posedge clk_in);
                            #1;
                        end
                        if (!rst_n) begin
                            aborted = 1'b1;
                        end else begin
                            if (c == 0) bits[j] = tx[g];
                            else if (tx[g] !== bits[j]) unstable++;
                            if (j == n - 1 && c == C - 1) begin
                                last_rdy  = rdy[g];
                                last_busy = busy[g];
                            end
                        end
                    end
                end
                if (aborted) begin
                    if (sb_size(g) > 0) exp = sb_pop(g);
                end else begin
                    check_eq($sformatf("dut%0d_bit_hold", g), unstable, 0);
                    check_eq($sformatf("dut%0d_ready_in_frame", g), last_rdy, 0);
                    check_eq($sformatf("dut%0d_busy_in_frame", g), last_busy, 1);
                    if (sb_size(g) == 0) begin
                        check_eq($sformatf("dut%0d_unexpected_frame", g), bits[8:1], 32'hFFFF_FFFF);
                    end else begin
                        exp = sb_pop(g);
                        check_eq($sformatf("dut%0d_data", g), bits[8:1], exp);
                        if (cfg_par(g) != 0)
                            check_eq($sformatf("dut%0d_parity", g), bits[9], par_model(g, exp));
                        for (int s = 0; s < cfg_stop(g); s++)
                            check_eq($sformatf("dut%0d_stop%0d", g, s), bits[n - 1 - s], 1);
                    end
                    @(posedge clk_in);
                    #1;
                    check_eq($sformatf("dut%0d_ready_after", g), rdy[g], 1);
                    check_eq($sformatf("dut%0d_busy_after", g), busy[g], 0);
                end
            end
        end
    endtask

    // Present a byte and wait for its handshake; hs is the cycle count just after the accepting edge.
    task automatic send(input int g, input logic [7:0] v, input bit hold, output int hs);
        int waitc = 0;
        @(negedge clk_in);
        din[g] = v;
        vld[g] = 1'b1;
        while (!rdy[g] && waitc < 2000) begin
            @(negedge clk_in);
            waitc++;
        end
        if (!rdy[g]) begin
            check_eq($sformatf("dut%0d_send_timeout", g), 0, 1);
            vld[g] = 1'b0;
            hs = -1;
        end else begin
            check_eq($sformatf("dut%0d_idle_before", g), tx[g], 1);
            sb_push(g, v);
            @(posedge clk_in);
            #1;
            hs = cyc;
            check_eq($sformatf("dut%0d_start_latency", g), tx[g], 0);
            check_eq($sformatf("dut%0d_busy_start", g), busy[g], 1);
            check_eq($sformatf("dut%0d_ready_start", g), rdy[g], 0);
            if (!hold) vld[g] = 1'b0;
            din[g] = ~v;
        end
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while ((busy[g] || sb_size(g) != 0) && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        repeat (2) @(negedge clk_in);
        check_eq($sformatf("dut%0d_idle_reached", g), (n < 3000), 1);
    endtask

    task automatic count_low(input int g, input int ncyc, output int lows);
        lows = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk_in);
            if (tx[g] !== 1'b1) lows++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs1, hs2, lows;
        for (int g = 0; g < NDUT; g++) begin
            din[g] = '0;
            vld[g] = 1'b0;
        end
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none

        // Reset state and a quiet line afterwards.
        repeat (10) @(negedge clk_in);
        for (int g = 0; g < NDUT; g++) begin
            check_eq($sformatf("dut%0d_rst_tx", g), tx[g], 1);
            check_eq($sformatf("dut%0d_rst_ready", g), rdy[g], 1);
            check_eq($sformatf("dut%0d_rst_busy", g), busy[g], 0);
        end
        rst_n = 1'b1;
        count_low(0, 1000, lows);
        check_eq("dut0_quiet_after_reset", lows, 0);
        for (int g = 1; g < NDUT; g++) check_eq($sformatf("dut%0d_quiet_after_reset", g), tx[g], 1);

        // 8N1, 8E2, 8O1 with 0xC5.
        send(0, 8'hC5, 1'b0, hs1);
        wait_idle(0);
        send(1, 8'hC5, 1'b0, hs1);
        wait_idle(1);
        send(2, 8'hC5, 1'b0, hs1);
        wait_idle(2);

        // Back-to-back on 8E2 with valid held; data_in scrambled during the first frame.
        send(1, 8'h00, 1'b1, hs1);
        send(1, 8'hFF, 1'b0, hs2);
        check_eq("dut1_frame_period", hs2 - hs1, nbits(1) * C + 1);
        wait_idle(1);

        // Valid pulsed mid-frame is ignored.
        send(0, 8'hA5, 1'b0, hs1);
        repeat (3 * C) @(negedge clk_in);
        din[0] = 8'h3C;
        vld[0] = 1'b1;
        @(negedge clk_in);
        vld[0] = 1'b0;
        wait_idle(0);
        count_low(0, 4 * C, lows);
        check_eq("dut0_no_second_frame", lows, 0);

        // Asynchronous reset during data bit 3 of 0x0F.
        send(0, 8'h0F, 1'b0, hs1);
        repeat (4 * C + C / 2) @(posedge clk_in);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("dut0_async_rst_tx", tx[0], 1);
        check_eq("dut0_async_rst_ready", rdy[0], 1);
        check_eq("dut0_async_rst_busy", busy[0], 0);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        count_low(0, 5 * C, lows);
        check_eq("dut0_no_resume", lows, 0);
        check_eq("dut0_idle_after_rst", busy[0], 0);
        send(0, 8'h81, 1'b0, hs1);
        wait_idle(0);

        // Every queued byte must have been seen on the line.
        for (int g = 0; g < NDUT; g++) begin
            wait_idle(g);
            check_eq($sformatf("dut%0d_sb_drained", g), sb_size(g), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
